// File: rtl/pfu_pkg.sv
// pfu_pkg: shared widths, zero constants and state encoding for the prefetch unit.
package pfu_pkg;
    localparam int PC_WIDTH   = 32;
    localparam int INST_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0]   ZERO_PC   = '0;
    localparam logic [INST_WIDTH-1:0] ZERO_INST = '0;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} pfu_state_e;
endpackage

// File: rtl/pfu_inst_queue.sv
// pfu_inst_queue: first-word-fall-through FIFO holding {pc, inst} pairs.
module pfu_inst_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0]   r_count;
    logic          w_push, w_pop;
    assign w_pop   = i_pop && r_count != '0;
    assign w_push  = i_push && (r_count != FULL || w_pop);
    assign o_data  = r_count != '0 ? r_mem[r_rd] : '0;
    assign o_count = r_count;
    always_ff @(posedge clk_i) begin
        if (rst_i || i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= r_rd + AW'(w_pop);
            r_wr    <= r_wr + AW'(w_push);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/pfu.sv
// pfu: prefetch unit issuing in-order fetches with credit-based flow control
// into a small instruction queue; flush redirects and drops in-flight responses.
module pfu import pfu_pkg::*; #(
    parameter logic [PC_WIDTH-1:0] RESET_PC    = ZERO_PC,
    parameter int                  QUEUE_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  pfu2mem_req_o,
    output logic [PC_WIDTH-1:0]   pfu2mem_addr_o,
    input  logic                  mem2pfu_gnt_i,
    input  logic                  mem2pfu_rsp_valid_i,
    input  logic [INST_WIDTH-1:0] mem2pfu_rsp_inst_i,
    input  logic                  ctrl2pfu_flush_i,
    input  logic [PC_WIDTH-1:0]   ctrl2pfu_redirect_pc_i,
    input  logic                  ctrl2pfu_stall_i,
    output logic                  pfu2dpu_valid_o,
    output logic [INST_WIDTH-1:0] pfu2dpu_inst_o,
    output logic [PC_WIDTH-1:0]   pfu2dpu_pc_o,
    input  logic                  dpu2pfu_ready_i
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW+1)'(QUEUE_DEPTH);
    pfu_state_e                   r_state, w_state_next;
    logic [PC_WIDTH-1:0]          r_fetch_pc, r_rsp_pc, w_redirect_pc;
    logic [CW-1:0]                r_outstanding, r_drop_cnt, w_out_next, w_drop_next, w_count;
    logic                         w_req, w_gnt, w_drop, w_push, w_pop;
    logic [PC_WIDTH+INST_WIDTH-1:0] w_head;
    // Credits: in-flight requests plus queued words never exceed the queue size.
    assign w_req = r_state == FETCH && !ctrl2pfu_stall_i && !ctrl2pfu_flush_i &&
                   ({1'b0, r_outstanding} + {1'b0, w_count} < DEPTH_EXT);
    assign w_gnt         = w_req && mem2pfu_gnt_i;
    assign w_drop        = mem2pfu_rsp_valid_i && r_drop_cnt != '0;
    assign w_push        = mem2pfu_rsp_valid_i && !w_drop && !ctrl2pfu_flush_i;
    assign w_pop         = pfu2dpu_valid_o && dpu2pfu_ready_i;
    assign w_out_next    = r_outstanding + CW'(w_gnt) - CW'(mem2pfu_rsp_valid_i);
    assign w_drop_next   = ctrl2pfu_flush_i ? w_out_next : r_drop_cnt - CW'(w_drop);
    assign w_redirect_pc = {ctrl2pfu_redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign pfu2mem_req_o   = w_req;
    assign pfu2mem_addr_o  = r_fetch_pc;
    assign pfu2dpu_valid_o = w_count != '0 && !ctrl2pfu_flush_i;
    assign {pfu2dpu_pc_o, pfu2dpu_inst_o} = w_head;
    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE)
            w_state_next = FETCH;
        else if (ctrl2pfu_flush_i || r_state == DRAIN)
            w_state_next = w_drop_next != '0 ? DRAIN : FETCH;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_drop_next;
            r_fetch_pc    <= ctrl2pfu_flush_i ? w_redirect_pc : w_gnt ? r_fetch_pc + 32'd4 : r_fetch_pc;
            r_rsp_pc      <= ctrl2pfu_flush_i ? w_redirect_pc : w_push ? r_rsp_pc + 32'd4 : r_rsp_pc;
        end
    end
    pfu_inst_queue #(
        .DEPTH(QUEUE_DEPTH),
        .W    (PC_WIDTH + INST_WIDTH)
    ) u_queue (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_clear(ctrl2pfu_flush_i),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data ({r_rsp_pc, mem2pfu_rsp_inst_i}),
        .o_data (w_head),
        .o_count(w_count)
    );
endmodule
